serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 4, operand and result width in bits (≥2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request a subtraction; sampled on a rising edge.
REQ-005 Port: a  input  WIDTH  minuend; sampled with start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled with start.
REQ-007 Port: y  output  WIDTH  difference a-b modulo 2^WIDTH; registered.
REQ-008 Port: borrow  output  1  final borrow-out; 1 when a<b unsigned.
REQ-009 Port: ovf  output  1  two's-complement overflow of a-b.
REQ-010 Port: busy  output  1  high while a subtraction is in progress.
REQ-011 Port: done  output  1  one-cycle pulse: y/borrow/ovf just became valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 Start acceptance: in IDLE or DONE with start=1 at an edge, the block SHALL load a and b into internal shift registers, clear the borrow flip-flop and bit counter, and enter RUN.
REQ-014 In RUN, start SHALL be ignored and a, b SHALL NOT be resampled.
REQ-015 RUN SHALL process one bit per edge, LSB first: d = ai^bi^br; br_next = (~ai&bi) | (~(ai^bi)&br).
REQ-016 Each RUN edge SHALL shift d into the MSB of the result shift register. Each RUN edge SHALL shift the operand registers right by one.
REQ-017 The bit counter SHALL count 0..WIDTH-1 in RUN. On the edge that processes bit WIDTH-1, the FSM SHALL go to DONE. RUN therefore lasts exactly WIDTH edges.
REQ-018 On entering DONE, y SHALL equal the full difference and borrow SHALL equal the final br.
REQ-019 On entering DONE, ovf SHALL equal (a[MSB]!=b[MSB]) && (y[MSB]!=a[MSB]), using the captured operands.
REQ-020 Latency: start accepted at edge k; done=1 during the cycle after edge k+WIDTH.
REQ-021 done SHALL be 1 only in DONE. DONE SHALL last one cycle, then go to IDLE, unless start=1, which goes directly to RUN.
REQ-022 busy SHALL be 1 only in RUN.
REQ-023 y, borrow and ovf SHALL hold their last completed values through IDLE and the next RUN until the next DONE.
REQ-024 Intermediate shift contents SHALL NOT be visible on y.
REQ-025 Back-to-back: start held high continuously SHALL yield one result every WIDTH+1 cycles.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, y=0, borrow=0, ovf=0, busy=0, done=0, and clear the counter, operand and borrow registers.
REQ-027 rst SHALL take priority over start and over any state, including mid-RUN.
REQ-028 A subtraction interrupted by reset SHALL be discarded, with no done pulse.

Verification
REQ-029 a=0101, b=0101, start 1 cycle -> after 4 RUN cycles done=1, y=0000, borrow=0, ovf=0; busy high exactly 4 cycles.
REQ-030 a=0011, b=0101 -> y=1110, borrow=1, ovf=0.
REQ-031 a=0111, b=1000 -> y=1111, borrow=1, ovf=1. Also a=1000, b=0001 -> y=0111, borrow=0, ovf=1.
REQ-032 Accept a=1001, b=0010; pulse start again with a=0000, b=1111 during RUN -> first result y=0111, borrow=0; the second start is ignored.
REQ-033 Accept a=1100, b=0001; assert rst for one cycle after 2 RUN cycles -> outputs all 0, IDLE, no done. A fresh start then completes normally.
REQ-034 Exhaustive: all 256 (a,b) pairs issued back-to-back with start held high -> each done shows y=(a-b) mod 16, borrow=(a<b), ovf per REQ-019, with a period of 5 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. It computes y = a - b, one bit per
//   clock edge, starting with the LSB. The result and its flags are published
//   together when the DONE state is entered.
//
// Ports
//   clk    : single clock. All state changes happen on the rising edge.
//   rst    : synchronous, active-high reset. It overrides every other input.
//   start  : request a subtraction. It is accepted in IDLE or DONE and
//            ignored in RUN.
//   a, b   : minuend and subtrahend. They are captured only when start is
//            accepted.
//   y      : registered difference a - b mod 2^WIDTH.
//   borrow : final borrow-out. It is 1 when a < b as unsigned numbers.
//   ovf    : two's-complement overflow of a - b.
//   busy   : high while in RUN.
//   done   : one-cycle pulse in DONE. It marks new y/borrow/ovf.
//
// Timing: when start is accepted at edge k, done is high during the cycle
// after edge k+WIDTH. If start stays high, the block produces one result every
// WIDTH+1 cycles.

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic ai;
    logic bi;
    logic d;
    logic br_nxt;
    logic last_bit;
    logic accept;

    // One full-subtractor slice. It operates on the current LSBs of the
    // operand shift registers.
    assign ai       = a_sh[0];
    assign bi       = b_sh[0];
    assign d        = ai ^ bi ^ br;
    assign br_nxt   = (~ai & bi) | (~(ai ^ bi) & br);
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);
    assign accept   = (state != RUN) && start;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- serial datapath and result registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            y      <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {d, res_sh[WIDTH-1:1]};
            br     <= br_nxt;
            cnt    <= cnt + 1'b1;
            // y is written only when the last bit is processed, so partial
            // results never appear on the output. By this bit the operands
            // have shifted right WIDTH-1 times, so ai and bi are the MSBs of
            // the captured operands and d is the MSB of the result.
            if (last_bit) begin
                y      <= {d, res_sh[WIDTH-1:1]};
                borrow <= br_nxt;
                ovf    <= (ai != bi) && (d != ai);
            end
        end
    end

endmodule
